// File: rtl/pe_mac_seq_pkg.sv
// -----------------------------------------------------------------------------
// pe_mac_seq_pkg
// Shared definitions for the MAC processing-element sequencer: default widths
// for the operand buffers, the vector-length field and the PE accumulator, the
// default PE pipeline depth, and the sequencer state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package pe_mac_seq_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;
    localparam int ACC_W_DEF  = 24;
    localparam int PE_LAT_DEF = 1;

    // Sequencer states; the encoding is shared with the PE and top-level control.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pe_mac_seq_if.sv
// -----------------------------------------------------------------------------
// pe_mac_seq_if
// Groups everything the sequencer exchanges with its neighbours: the request
// side from top-level control (start/len/base_a/base_b/hold, busy/done/result),
// the operand-buffer read port (buf_rd_en/buf_addr_a/buf_addr_b) and the PE
// strobes and accumulator (pe_en/pe_clr/pe_acc).
//   modport slave  : the sequencer itself
//   modport master : the surrounding environment (control, buffers, PE)
// -----------------------------------------------------------------------------
interface pe_mac_seq_if
    import pe_mac_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) ();

    logic              start;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic              hold;
    logic              busy;
    logic              done;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_addr_a;
    logic [ADDR_W-1:0] buf_addr_b;
    logic              pe_en;
    logic              pe_clr;
    logic [ACC_W-1:0]  pe_acc;
    logic [ACC_W-1:0]  result;

    modport slave (
        input  start, len, base_a, base_b, hold, pe_acc,
        output busy, done, buf_rd_en, buf_addr_a, buf_addr_b, pe_en, pe_clr, result
    );

    modport master (
        output start, len, base_a, base_b, hold, pe_acc,
        input  busy, done, buf_rd_en, buf_addr_a, buf_addr_b, pe_en, pe_clr, result
    );

endinterface

// File: rtl/pe_mac_addr_gen.sv
// -----------------------------------------------------------------------------
// pe_mac_addr_gen
// Step counter and operand-buffer address generator for pe_mac_seq.
//   clk, rst       : clock, synchronous active-high reset
//   load           : latch len/base_a/base_b and clear the step counter
//   step           : a read is issued this cycle; advance the counter
//   len            : number of steps in the request
//   base_a, base_b : first addresses of the A and B buffers
//   addr_a, addr_b : base + count, wrapping modulo 2**ADDR_W
//   first          : counter is at step 0
//   last           : counter is at step len-1 (the final read)
// -----------------------------------------------------------------------------
module pe_mac_addr_gen
    import pe_mac_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              first,
    output logic              last
);

    logic [LEN_W-1:0]  cnt_r;
    logic [LEN_W-1:0]  len_r;
    logic [ADDR_W-1:0] base_a_r;
    logic [ADDR_W-1:0] base_b_r;
    logic [LEN_W-1:0]  len_m1_s;

    // Request capture and step counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {LEN_W{1'b0}};
            len_r    <= {LEN_W{1'b0}};
            base_a_r <= {ADDR_W{1'b0}};
            base_b_r <= {ADDR_W{1'b0}};
        end else if (load) begin
            cnt_r    <= {LEN_W{1'b0}};
            len_r    <= len;
            base_a_r <= base_a;
            base_b_r <= base_b;
        end else if (step) begin
            cnt_r    <= cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r    <= cnt_r;
        end
    end

    // Only meaningful while fetching, where len is known to be non-zero.
    assign len_m1_s = len_r - {{(LEN_W-1){1'b0}}, 1'b1};

    // Addresses wrap silently; the add is simply truncated to ADDR_W.
    assign addr_a = base_a_r + ADDR_W'(cnt_r);
    assign addr_b = base_b_r + ADDR_W'(cnt_r);
    assign first  = (cnt_r == {LEN_W{1'b0}});
    assign last   = (cnt_r == len_m1_s);

endmodule

// File: rtl/pe_mac_seq.sv
// -----------------------------------------------------------------------------
// pe_mac_seq
// Sequencer for one MAC processing element. On an accepted start it streams
// len operand-pair reads from the A/B buffers (1-cycle read latency), drives
// pe_en/pe_clr one cycle behind each read, waits out the PE pipeline, captures
// the accumulator into result and pulses done for one cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pe_mac_seq_if.slave
//              in : start, len, base_a, base_b, hold, pe_acc
//              out: busy, done, buf_rd_en, buf_addr_a, buf_addr_b,
//                   pe_en, pe_clr, result
// Build option: define PE_MAC_SEQ_RELU_EN to clamp negative accumulators to
// zero on capture; otherwise the accumulator is captured unchanged.
// -----------------------------------------------------------------------------
module pe_mac_seq
    import pe_mac_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PE_LAT = PE_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    pe_mac_seq_if.slave bus
);

    localparam int DRAIN_W = $clog2(PE_LAT + 1) + 1;

    seq_state_e         state_r;
    seq_state_e         state_s;
    logic               rd_en_s;
    logic               load_s;
    logic               capture_s;
    logic               first_s;
    logic               last_s;
    logic               pe_en_r;
    logic               pe_clr_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [ACC_W-1:0]   result_r;

    // Value stored into result when the drain completes.
    function automatic logic [ACC_W-1:0] capture_val(input logic [ACC_W-1:0] acc);
`ifdef PE_MAC_SEQ_RELU_EN
        if (acc[ACC_W-1]) begin
            capture_val = {ACC_W{1'b0}};
        end else begin
            capture_val = acc;
        end
`else
        capture_val = acc;
`endif
    endfunction

    pe_mac_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .step   (rd_en_s),
        .len    (bus.len),
        .base_a (bus.base_a),
        .base_b (bus.base_b),
        .addr_a (bus.buf_addr_a),
        .addr_b (bus.buf_addr_b),
        .first  (first_s),
        .last   (last_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_s   = state_r;
        rd_en_s   = 1'b0;
        load_s    = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    load_s = 1'b1;
                    if (bus.len != {LEN_W{1'b0}}) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // hold gates the read in the same cycle it is raised.
                if (!bus.hold) begin
                    rd_en_s = 1'b1;
                    if (last_s) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // PE_LAT+1 drain cycles: one for the last pe_en, PE_LAT for the PE.
                if (drain_cnt_r == DRAIN_W'(PE_LAT)) begin
                    capture_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s   = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // PE strobes trail the buffer read by the buffer's one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_en_r  <= 1'b0;
            pe_clr_r <= 1'b0;
        end else begin
            pe_en_r  <= rd_en_s;
            pe_clr_r <= rd_en_s & first_s;
        end
    end

    // Drain cycle counter, parked at zero outside DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt_r <= {DRAIN_W{1'b0}};
        end else if (state_r == ST_DRAIN) begin
            drain_cnt_r <= drain_cnt_r + {{(DRAIN_W-1){1'b0}}, 1'b1};
        end else begin
            drain_cnt_r <= {DRAIN_W{1'b0}};
        end
    end

    // Result register: cleared on every accepted start, loaded at end of drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= {ACC_W{1'b0}};
        end else if (load_s) begin
            result_r <= {ACC_W{1'b0}};
        end else if (capture_s) begin
            result_r <= capture_val(bus.pe_acc);
        end else begin
            result_r <= result_r;
        end
    end

    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.done      = (state_r == ST_DONE);
    assign bus.buf_rd_en = rd_en_s;
    assign bus.pe_en     = pe_en_r;
    assign bus.pe_clr    = pe_clr_r;
    assign bus.result    = result_r;

endmodule

// File: tb/tb_pe_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_pe_mac_seq
// Bench for pe_mac_seq: 1-cycle operand buffers, a behavioural PE (PE_LAT=1),
// directed and randomized requests. The stimulus pushes expected read
// addresses and expected {result, done cycle} entries; a monitor pops and
// compares them whenever the DUT issues a read or pulses done.
// -----------------------------------------------------------------------------
module tb_pe_mac_seq;

    typedef struct {
        logic [23:0] result;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic signed [7:0] mem_a [256];
    logic signed [7:0] mem_b [256];
    logic signed [7:0] rd_a;
    logic signed [7:0] rd_b;
    logic signed [23:0] prod;

    exp_t        exp_q [$];
    logic [15:0] addr_q [$];

    bit mon_en    = 1'b0;
    bit idle_chk  = 1'b0;
    bit stim_done = 1'b0;
    int tests     = 0;
    int fails     = 0;

    pe_mac_seq_if #(.ADDR_W(8), .LEN_W(8), .ACC_W(24)) bus ();

    pe_mac_seq #(.ADDR_W(8), .LEN_W(8), .ACC_W(24), .PE_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand buffers with one-cycle read latency and a behavioural PE.
    assign prod = 24'(rd_a) * 24'(rd_b);
    always @(posedge clk) begin
        if (bus.buf_rd_en) begin
            rd_a <= mem_a[bus.buf_addr_a];
            rd_b <= mem_b[bus.buf_addr_b];
        end
        if (bus.pe_en) bus.pe_acc <= bus.pe_clr ? prod : bus.pe_acc + prod;
    end

    // Expected response of one request: dot product over wrapped addresses.
    task automatic push_expect(input logic [7:0] l, input logic [7:0] ba,
                               input logic [7:0] bb, output int sum);
        sum = 0;
        for (int i = 0; i < int'(l); i++) begin
            logic [7:0] aa, ab;
            aa = 8'(int'(ba) + i);
            ab = 8'(int'(bb) + i);
            addr_q.push_back({aa, ab});
            sum += int'(mem_a[aa]) * int'(mem_b[ab]);
        end
`ifdef PE_MAC_SEQ_RELU_EN
        if (sum < 0) sum = 0;
`endif
    endtask

    task automatic run_op(input logic [7:0] l, input logic [7:0] ba, input logic [7:0] bb,
                          input logic [31:0] hold_mask, input int hold_pct, input int spur_pct);
        int   sum, t0, reads, holds, k, exp_done;
        bit   h;
        exp_t e;
        push_expect(l, ba, bb, sum);
        bus.start = 1'b1; bus.len = l; bus.base_a = ba; bus.base_b = bb; bus.hold = 1'b0;
        t0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.len = 8'($urandom); bus.base_a = 8'($urandom); bus.base_b = 8'($urandom);
        reads = 0; holds = 0; k = 0;
        if (l == 8'd0) begin
            exp_done = t0 + 1;
        end else begin
            while (reads < int'(l)) begin
                h = ((k < 32) && hold_mask[k]) || (int'($urandom_range(99)) < hold_pct);
                bus.hold  = h;
                bus.start = (int'($urandom_range(99)) < spur_pct);
                if (h) holds++; else reads++;
                k++;
                @(posedge clk); #1;
            end
            exp_done = t0 + int'(l) + holds + 3;
        end
        e.result = 24'(sum); e.done_cyc = exp_done;
        exp_q.push_back(e);
        while (cyc <= exp_done) begin
            bus.hold  = 1'($urandom_range(1));
            bus.start = (int'($urandom_range(99)) < spur_pct);
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.hold = 1'b0;
    endtask

    // Request interrupted by reset two cycles after start.
    task automatic run_reset_op(input logic [7:0] ba, input logic [7:0] bb);
        addr_q.push_back({ba, bb});
        addr_q.push_back({8'(ba + 8'd1), 8'(bb + 8'd1)});
        bus.start = 1'b1; bus.len = 8'd4; bus.base_a = ba; bus.base_b = bb; bus.hold = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; idle_chk = 1'b1;
        @(posedge clk); #1;
        idle_chk = 1'b0;
    endtask

    // Stimulus.
    initial begin
        bus.start = 1'b0; bus.len = 8'd0; bus.base_a = 8'd0; bus.base_b = 8'd0; bus.hold = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = 8'($urandom);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; mon_en = 1'b1; idle_chk = 1'b1;
        @(posedge clk); #1;
        idle_chk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_a[8'h10 + i] = 8'(i + 1);
            mem_b[8'h20 + i] = 8'(i + 5);
        end
        run_op(8'd4, 8'h10, 8'h20, 32'h0, 0, 0);
        run_op(8'd4, 8'h10, 8'h20, 32'h6, 0, 0);
        run_op(8'd0, 8'h33, 8'h44, 32'h0, 0, 0);
        run_op(8'd4, 8'hFE, 8'h00, 32'h0, 0, 0);
        run_reset_op(8'h10, 8'h20);
        run_op(8'd4, 8'h10, 8'h20, 32'h0, 0, 0);
        mem_a[8'h40] = -8'sd5;
        mem_b[8'h50] = 8'sd4;
        run_op(8'd1, 8'h40, 8'h50, 32'h0, 0, 60);
        for (int n = 0; n < 40; n++) begin
            run_op(8'($urandom_range(20)), 8'($urandom), 8'($urandom), 32'h0, 25, 20);
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
        end
        stim_done = 1'b1;
    end

    // Monitor / scoreboard.
    initial begin : monitor
        int   drain_wait;
        exp_t e;
        logic [15:0] ea;
        drain_wait = 0;
        forever begin
            @(negedge clk);
            if (mon_en && idle_chk) begin
                tests++;
                if ({bus.busy, bus.done, bus.buf_rd_en, bus.buf_addr_a, bus.buf_addr_b,
                     bus.pe_en, bus.pe_clr, bus.result} !== 45'd0) begin
                    fails++;
                    $display("FAIL idle_after_reset: busy=%b done=%b rd=%b a=%h b=%h en=%b clr=%b res=%h, required all 0",
                             bus.busy, bus.done, bus.buf_rd_en, bus.buf_addr_a, bus.buf_addr_b,
                             bus.pe_en, bus.pe_clr, bus.result);
                end
            end
            if (mon_en && bus.buf_rd_en === 1'b1) begin
                tests++;
                if (addr_q.size() == 0) begin
                    fails++;
                    $display("FAIL read_addr: unexpected read a=%h b=%h at cycle %0d",
                             bus.buf_addr_a, bus.buf_addr_b, cyc);
                end else begin
                    ea = addr_q.pop_front();
                    if ({bus.buf_addr_a, bus.buf_addr_b} !== ea) begin
                        fails++;
                        $display("FAIL read_addr: got a=%h b=%h, required a=%h b=%h",
                                 bus.buf_addr_a, bus.buf_addr_b, ea[15:8], ea[7:0]);
                    end
                end
            end
            if (mon_en && bus.done === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL done: unexpected done at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.result !== e.result) begin
                        fails++;
                        $display("FAIL result: got %0d, required %0d",
                                 $signed(bus.result), $signed(e.result));
                    end
                    tests++;
                    if (cyc != e.done_cyc) begin
                        fails++;
                        $display("FAIL done_cycle: got %0d, required %0d", cyc, e.done_cyc);
                    end
                end
            end
            if (stim_done) begin
                drain_wait++;
                if ((exp_q.size() == 0 && addr_q.size() == 0) || drain_wait > 100) begin
                    tests++;
                    if (exp_q.size() != 0 || addr_q.size() != 0) begin
                        fails++;
                        $display("FAIL pending: got %0d dones and %0d reads outstanding, required 0",
                                 exp_q.size(), addr_q.size());
                    end
                    $display("[TB] %0d tests run, %0d failed", tests, fails);
                    $finish;
                end
            end
        end
    end

    // Absolute time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
